// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between producer clients, the write arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_write_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          grant_valid;
  logic [IDW-1:0]                grant_id;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready clients.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]        beat_q, beat_d;
  logic [IDW-1:0]        winner;
  logic                  win_found;
  logic                  own_valid;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  beat_wr;
  logic                  last_beat;
  int unsigned           idx;

  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_valid = bus.req_valid[i];
        own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign beat_wr   = (state_q == GRANT) && own_valid && !bus.fifo_full;
  assign last_beat = (beat_q == BCW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    win_found = 1'b0;
    winner    = '0;
    idx       = 0;

    // Search upward from rr_ptr, wrapping so indices >= NUM_REQ never appear.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && bus.req_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        winner    = IDW'(idx);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = winner;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if ((beat_wr && last_beat) || !own_valid) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          beat_d   = '0;
        end else if (beat_wr) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.fifo_write_en = 1'b0;
    bus.fifo_data_in  = '0;
    bus.grant_valid   = 1'b0;
    bus.grant_id      = '0;
    if (state_q == GRANT) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (owner_q == IDW'(i)) bus.req_ready[i] = !bus.fifo_full;
      end
      bus.fifo_write_en = beat_wr;
      bus.fifo_data_in  = own_data;
      bus.grant_valid   = 1'b1;
      bus.grant_id      = owner_q;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus burst, back-pressure and reset sequences.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) bus3 ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic        full;
    logic [15:0] exp;  // {req_ready, write_en, data_in, grant_valid, grant_id}
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [3:0] v, input logic [31:0] d, input logic f,
                     input logic [3:0] rdy, input logic we, input logic [7:0] dout,
                     input logic gv, input logic [1:0] gid);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.full = f;
    x.exp = {rdy, we, dout, gv, gid};
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;  bus.req_data = '0;  bus.fifo_full = 1'b0;
    bus3.req_valid = '0; bus3.req_data = '0; bus3.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] outs4();
    return {bus.req_ready, bus.fifo_write_en, bus.fifo_data_in, bus.grant_valid, bus.grant_id};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fifo_q[$];
    logic [9:0]  wlog[$];
    int          cnt[4];
    int          nb[4];
    int          owners[5];
    int          full_cycles, writes, saw_full, o;
    logic [9:0]  expw;
    int          seq6[4];
    logic [1:0]  g;
    logic [14:0] exp6;

    // Outputs stay idle while reset is held, even with every request valid.
    rst_n = 1'b0;
    bus.req_valid = 4'hF; bus.req_data = 32'h44332211; bus.fifo_full = 1'b0;
    bus3.req_valid = '0;  bus3.req_data = '0;          bus3.fifo_full = 1'b0;
    #1;
    check("reset_outputs", 64'(outs4()), 64'h0);

    // Lone requester 0 burst of three, then rr_ptr=1 shown by requester 1 winning over 0.
    add(1, 4'b0001, 32'h00000011, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b0001, 32'h00000011, 0, 4'b0001, 1, 8'h11, 1, 2'd0);
    add(0, 4'b0001, 32'h00000012, 0, 4'b0001, 1, 8'h12, 1, 2'd0);
    add(0, 4'b0001, 32'h00000013, 0, 4'b0001, 1, 8'h13, 1, 2'd0);
    add(0, 4'b0000, 32'h00000000, 0, 4'b0001, 0, 8'h00, 1, 2'd0);
    add(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b0011, 32'h00002101, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b0011, 32'h00002101, 0, 4'b0010, 1, 8'h21, 1, 2'd1);
    add(0, 4'b0000, 32'h00000000, 0, 4'b0010, 0, 8'h00, 1, 2'd1);
    add(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    // Owner 1 stalled by fifo_full for three cycles at beat 2.
    add(1, 4'b0010, 32'h0000A000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b0010, 32'h0000A000, 0, 4'b0010, 1, 8'hA0, 1, 2'd1);
    add(0, 4'b0010, 32'h0000A100, 0, 4'b0010, 1, 8'hA1, 1, 2'd1);
    add(0, 4'b0010, 32'h0000A200, 1, 4'b0000, 0, 8'hA2, 1, 2'd1);
    add(0, 4'b0010, 32'h0000A200, 1, 4'b0000, 0, 8'hA2, 1, 2'd1);
    add(0, 4'b0010, 32'h0000A200, 1, 4'b0000, 0, 8'hA2, 1, 2'd1);
    add(0, 4'b0010, 32'h0000A200, 0, 4'b0010, 1, 8'hA2, 1, 2'd1);
    add(0, 4'b0010, 32'h0000A300, 0, 4'b0010, 1, 8'hA3, 1, 2'd1);
    add(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    // Owner 2 releases with 1 and 3 pending: 3 next, then 1.
    add(1, 4'b0100, 32'h30201000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b1110, 32'h30201000, 0, 4'b0100, 1, 8'h20, 1, 2'd2);
    add(0, 4'b1010, 32'h30201000, 0, 4'b0100, 0, 8'h20, 1, 2'd2);
    add(0, 4'b1010, 32'h30201000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b1010, 32'h30201000, 0, 4'b1000, 1, 8'h30, 1, 2'd3);
    add(0, 4'b0010, 32'h30201000, 0, 4'b1000, 0, 8'h30, 1, 2'd3);
    add(0, 4'b0010, 32'h30201000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b0010, 32'h30201000, 0, 4'b0010, 1, 8'h10, 1, 2'd1);
    add(0, 4'b0000, 32'h30201000, 0, 4'b0010, 0, 8'h10, 1, 2'd1);
    add(0, 4'b0000, 32'h30201000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      @(negedge clk);
      bus.req_valid = vecs[k].v;
      bus.req_data  = vecs[k].d;
      bus.fifo_full = vecs[k].full;
      #1;
      check($sformatf("vec%0d", k), 64'(outs4()), 64'(vecs[k].exp));
    end

    // All four requesters streaming into a depth-8 FIFO that drains after 3 full cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; nb[i] = 0; end
    full_cycles = 0; writes = 0; saw_full = 0;
    for (int cyc = 0; cyc < 200 && writes < 20; cyc++) begin
      @(negedge clk);
      if (fifo_q.size() == 8 && full_cycles == 3) begin
        fifo_q.delete();
        full_cycles = 0;
      end
      bus.fifo_full = (fifo_q.size() == 8);
      bus.req_valid = 4'hF;
      for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = {4'(i), 4'(cnt[i])};
      #1;
      if (bus.fifo_full) begin
        saw_full = 1;
        check("full_no_write", 64'(bus.fifo_write_en), 64'h0);
        check("full_no_ready", 64'(bus.req_ready), 64'h0);
        full_cycles++;
      end
      if (bus.fifo_write_en) begin
        fifo_q.push_back(bus.fifo_data_in);
        wlog.push_back({bus.grant_id, bus.fifo_data_in});
        writes++;
      end
      for (int i = 0; i < 4; i++) if (bus.req_valid[i] && bus.req_ready[i]) cnt[i]++;
    end
    check("stream_write_count", 64'(writes), 64'd20);
    check("stream_saw_full", 64'(saw_full), 64'd1);
    owners = '{0, 1, 2, 3, 0};
    for (int b = 0; b < 5; b++) begin
      o = owners[b];
      for (int j = 0; j < 4; j++) begin
        expw = {2'(o), 4'(o), 4'(nb[o] * 4 + j)};
        if (b * 4 + j < wlog.size())
          check($sformatf("stream_word%0d", b * 4 + j), 64'(wlog[b*4+j]), 64'(expw));
      end
      nb[o]++;
    end

    // Asynchronous reset in the middle of owner 3's burst.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid = 4'b1000;
      bus.req_data  = {8'h30 + 8'(k > 0 ? k - 1 : 0), 24'h0};
    end
    @(negedge clk);
    bus.req_data = 32'h32000005;
    #1;
    check("rst_mid_pre", 64'(outs4()), 64'({4'b1000, 1'b1, 8'h32, 1'b1, 2'd3}));
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_async", 64'(outs4()), 64'h0);
    bus.req_valid = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_idle", 64'(outs4()), 64'h0);
    @(negedge clk);
    #1;
    check("rst_lowest_first", 64'(outs4()), 64'({4'b0001, 1'b1, 8'h05, 1'b1, 2'd0}));

    // Single-beat bursts across three requesters, alternating IDLE/GRANT.
    do_reset();
    seq6 = '{0, 1, 2, 0};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus3.req_valid = 3'b111;
      bus3.req_data  = 24'hC2C1C0;
      bus3.fifo_full = 1'b0;
      #1;
      if (k % 2 == 0) exp6 = '0;
      else begin
        g = 2'(seq6[k/2]);
        exp6 = {3'(3'b001 << g), 1'b1, 8'hC0 + 8'(g), 1'b1, g};
      end
      check($sformatf("burst1_cyc%0d", k),
            64'({bus3.req_ready, bus3.fifo_write_en, bus3.fifo_data_in, bus3.grant_valid, bus3.grant_id}),
            64'(exp6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
